// File: rtl/reg_alu_pkg.sv
// Shared opcodes, flag bit positions and sequencer state encoding for reg_alu_seq.
package reg_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/reg_alu_regfile.sv
// NREGS x WIDTH register file: two combinational read ports, one shared write port
// where the ALU writeback overrides an external load to the same index.
module reg_alu_regfile #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             alu_we,
    input  logic [AW-1:0]    alu_addr,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             ext_we,
    input  logic [AW-1:0]    ext_addr,
    input  logic [WIDTH-1:0] ext_data
);

    logic [WIDTH-1:0] regs [NREGS];

    assign rdata_a = regs[ra];
    assign rdata_b = regs[rb];

    // Later assignment wins, so the ALU takes the index when both target it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ext_we) begin
                regs[ext_addr] <= ext_data;
            end
            if (alu_we) begin
                regs[alu_addr] <= alu_data;
            end
        end
    end

endmodule

// File: rtl/reg_alu_seq.sv
// Registered ALU with register file, valid/ready command port and an iterative
// shift-add multiplier. state | meaning: ST_IDLE accepts commands, ST_MUL multiplies.
module reg_alu_seq
    import reg_alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS),
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [AW-1:0]    cmd_rd,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       flags,
    output logic             busy
);

    state_t             state;
    logic [SW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [AW-1:0]      mul_rd;

    logic [WIDTH-1:0]   rd_a;
    logic [WIDTH-1:0]   rd_b;
    logic               accept;
    logic               accept_single;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_prod;
    logic [3:0]         mul_flg;

    logic [WIDTH-1:0]   alu_res;
    logic [3:0]         alu_flg;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [SW-1:0]      sh;
    logic               carry_in_msb;

    logic               alu_we;
    logic [AW-1:0]      alu_addr;
    logic [WIDTH-1:0]   alu_data;

    assign cmd_ready     = (state == ST_IDLE);
    assign busy          = (state == ST_MUL);
    assign accept        = cmd_valid & cmd_ready;
    assign accept_single = accept & (cmd_op != OP_MUL);

    reg_alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (cmd_ra),
        .rb       (cmd_rb),
        .rdata_a  (rd_a),
        .rdata_b  (rd_b),
        .alu_we   (alu_we),
        .alu_addr (alu_addr),
        .alu_data (alu_data),
        .ext_we   (wr_en),
        .ext_addr (wr_addr),
        .ext_data (wr_data)
    );

    // Shifts are done one bit wider so the bit shifted out lands in the extra position.
    always_comb begin
        sh           = rd_b[SW-1:0];
        b_eff        = (cmd_op == OP_SUB) ? ~rd_b : rd_b;
        sum_ext      = {1'b0, rd_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (cmd_op == OP_SUB)};
        carry_in_msb = rd_a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_ext[WIDTH-1];
        shl_ext      = {1'b0, rd_a} << sh;
        shr_ext      = {rd_a, 1'b0} >> sh;
        alu_res      = '0;
        alu_flg      = '0;
        case (cmd_op)
            OP_ADD, OP_SUB: begin
                alu_res        = sum_ext[WIDTH-1:0];
                alu_flg[FLG_C] = sum_ext[WIDTH];
                alu_flg[FLG_V] = carry_in_msb ^ sum_ext[WIDTH];
            end
            OP_AND: alu_res = rd_a & rd_b;
            OP_OR:  alu_res = rd_a | rd_b;
            OP_XOR: alu_res = rd_a ^ rd_b;
            OP_SHL: begin
                alu_res        = shl_ext[WIDTH-1:0];
                alu_flg[FLG_C] = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res        = shr_ext[WIDTH:1];
                alu_flg[FLG_C] = shr_ext[0];
            end
            default: alu_res = '0;
        endcase
        alu_flg[FLG_N] = alu_res[WIDTH-1];
        alu_flg[FLG_Z] = (alu_res == '0);
    end

    // Final partial product is folded in combinationally on the last MUL cycle.
    always_comb begin
        mul_prod       = acc + (mplier[0] ? mcand : '0);
        mul_last       = (state == ST_MUL) && (cnt == SW'(WIDTH - 1));
        mul_flg        = '0;
        mul_flg[FLG_N] = mul_prod[WIDTH-1];
        mul_flg[FLG_Z] = (mul_prod[WIDTH-1:0] == '0);
        mul_flg[FLG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    end

    assign alu_we   = accept_single | mul_last;
    assign alu_addr = mul_last ? mul_rd : cmd_rd;
    assign alu_data = mul_last ? mul_prod[WIDTH-1:0] : alu_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            mul_rd    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            flags     <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (cmd_op == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, rd_a};
                            mplier <= rd_b;
                            acc    <= '0;
                            cnt    <= '0;
                            mul_rd <= cmd_rd;
                            state  <= ST_MUL;
                        end else begin
                            res_data  <= alu_res;
                            flags     <= alu_flg;
                            res_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc    <= mul_prod;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SW'(1);
                    if (mul_last) begin
                        res_data  <= mul_prod[WIDTH-1:0];
                        flags     <= mul_flg;
                        res_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_alu_seq.sv
// Scoreboard bench for reg_alu_seq: driver pushes expected results from an
// arithmetic reference model, a monitor pops and compares on res_valid.
module tb_reg_alu_seq;

    localparam int W  = 16;
    localparam int NR = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_ra;
    logic [2:0]  cmd_rb;
    logic [2:0]  cmd_rd;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        res_valid;
    logic [15:0] res_data;
    logic [3:0]  flags;
    logic        busy;

    reg_alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_rd    (cmd_rd),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .res_valid (res_valid),
        .res_data  (res_data),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] mregs [NR];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: returns {N,Z,C,V, result} from plain arithmetic on the operands.
    function automatic logic [19:0] ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        longint      p;
        int          sh;
        logic [15:0] r;
        logic        c;
        logic        v;
        sh = int'(b[3:0]);
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        p  = 0;
        case (op)
            3'd0: begin
                p = longint'(a) + longint'(b);
                r = p[15:0];
                c = (p > 65535);
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                r = a << sh;
                c = (sh != 0) ? a[16 - sh] : 1'b0;
            end
            3'd6: begin
                r = a >> sh;
                c = (sh != 0) ? a[sh - 1] : 1'b0;
            end
            default: begin
                p = longint'(a) * longint'(b);
                r = p[15:0];
                c = ((p >> 16) != 0);
            end
        endcase
        return {r[15], (r == 16'h0), c, v, r};
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && res_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_res_valid: got res_data %0h expected no result (cycle %0d)", res_data, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("res_cycle", cyc, e.cyc);
                    chk("res_data", int'(res_data), int'(e.res));
                    chk("flags", int'(flags), int'(e.flg));
                end
            end else if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                total++;
                bad++;
                $display("FAIL missing_result: got none expected %0h at cycle %0d", e.res, e.cyc);
            end
        end
    end

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        mregs[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd, input logic ext, input logic [2:0] ea,
                         input logic [15:0] ed, output int busy_cnt);
        int          waits;
        logic [19:0] r;
        logic [2:0]  a2;
        exp_t        e;
        busy_cnt = 0;
        waits    = 0;
        while (cmd_ready !== 1'b1 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (cmd_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL cmd_ready_timeout: got %b expected 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rd    = rd;
        wr_en     = ext;
        wr_addr   = ea;
        wr_data   = ed;
        r     = ref_op(op, mregs[ra], mregs[rb]);
        e.res = r[15:0];
        e.flg = r[19:16];
        e.cyc = cyc + 1 + ((op == 3'd7) ? W : 0);
        sbq.push_back(e);
        if (ext) mregs[ea] = ed;
        if (op != 3'd7) mregs[rd] = r[15:0];
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_en     = 1'b0;
        if (op == 3'd7) begin
            waits = 0;
            while (cmd_ready !== 1'b1 && waits < 100) begin
                if (busy === 1'b1) busy_cnt++;
                if ($urandom_range(0, 2) == 0) begin
                    a2 = 3'($urandom_range(0, 7));
                    if (a2 != rd) begin
                        wr_en    = 1'b1;
                        wr_addr  = a2;
                        wr_data  = 16'($urandom);
                        mregs[a2] = wr_data;
                    end
                end
                @(negedge clk);
                wr_en = 1'b0;
                waits++;
            end
            mregs[rd] = r[15:0];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int          bc;
        logic [2:0]  op;
        logic [15:0] spec [4];
        spec[0] = 16'h0000;
        spec[1] = 16'hFFFF;
        spec[2] = 16'h8000;
        spec[3] = 16'h7FFF;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_ra    = '0;
        cmd_rb    = '0;
        cmd_rd    = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_res_valid", int'(res_valid), 0);
        chk("reset_res_data", int'(res_data), 0);
        chk("reset_flags", int'(flags), 0);
        rst_n = 1'b1;
        @(negedge clk);

        load(3'd1, 16'h7FFF);
        load(3'd2, 16'h0001);
        issue(3'd0, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0, bc);
        issue(3'd3, 3'd3, 3'd3, 3'd0, 1'b0, 3'd0, 16'h0, bc);

        load(3'd1, 16'd5);
        load(3'd2, 16'd5);
        issue(3'd1, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0, bc);
        load(3'd1, 16'd0);
        load(3'd2, 16'd1);
        issue(3'd1, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0, bc);

        load(3'd1, 16'd300);
        load(3'd2, 16'd300);
        issue(3'd7, 3'd1, 3'd2, 3'd4, 1'b0, 3'd0, 16'h0, bc);
        chk("mul_busy_cycles", bc, W);
        issue(3'd3, 3'd4, 3'd4, 3'd7, 1'b0, 3'd0, 16'h0, bc);

        load(3'd1, 16'd1);
        load(3'd2, 16'd1);
        issue(3'd0, 3'd1, 3'd2, 3'd1, 1'b0, 3'd0, 16'h0, bc);
        issue(3'd0, 3'd1, 3'd2, 3'd1, 1'b0, 3'd0, 16'h0, bc);
        issue(3'd0, 3'd1, 3'd2, 3'd1, 1'b0, 3'd0, 16'h0, bc);

        issue(3'd0, 3'd1, 3'd2, 3'd5, 1'b1, 3'd5, 16'hAAAA, bc);
        issue(3'd3, 3'd5, 3'd5, 3'd0, 1'b0, 3'd0, 16'h0, bc);
        issue(3'd0, 3'd1, 3'd2, 3'd5, 1'b1, 3'd6, 16'hAAAA, bc);
        issue(3'd3, 3'd6, 3'd6, 3'd0, 1'b0, 3'd0, 16'h0, bc);

        // MUL aborted by reset eight cycles after acceptance: no result may appear.
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        cmd_ra    = 3'd1;
        cmd_rb    = 3'd2;
        cmd_rd    = 3'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_res_data", int'(res_data), 0);
        chk("abort_flags", int'(flags), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_abort_cmd_ready", int'(cmd_ready), 1);
        issue(3'd3, 3'd4, 3'd3, 3'd0, 1'b0, 3'd0, 16'h0, bc);

        load(3'd1, 16'h8001);
        load(3'd2, 16'h0010);
        issue(3'd5, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0, bc);
        load(3'd2, 16'h0001);
        issue(3'd5, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0, bc);
        issue(3'd6, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0, bc);

        for (int i = 0; i < NR; i++) load(3'(i), 16'($urandom));
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                load(3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 0) ? spec[$urandom_range(0, 3)] : 16'($urandom));
            end
            op = 3'($urandom_range(0, 7));
            issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 16'($urandom), bc);
            if (op == 3'd7) chk("rand_mul_busy_cycles", bc, W);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        repeat (25) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
